// File: rtl/ext_16_32_core.sv
// Immediate extender: widens an IN_W-bit field to OUT_W bits by zero- or sign-extension,
// with a combinational result and a registered copy qualified by in_valid.
module ext_16_32_core #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid
);

    logic [OUT_W-1:0] ext_c;

    // Zero-width padding is illegal, so the equal-width case is a straight pass-through.
    generate
        if (IN_W == OUT_W) begin : g_pass
            assign ext_c = in;
        end else begin : g_ext
            localparam int unsigned PAD_W = OUT_W - IN_W;
            logic [PAD_W-1:0] pad_c;
            assign pad_c = sel ? {PAD_W{in[IN_W-1]}} : {PAD_W{1'b0}};
            assign ext_c = {pad_c, in};
        end
    endgenerate

    assign out = ext_c;

    // Capture on every valid input; out_q holds across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= ext_c;
            end
        end
    end

endmodule

// File: tb/tb_ext_16_32_core.sv
// Randomized self-checking bench for ext_16_32_core against an arithmetic reference model.
module tb_ext_16_32_core;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [15:0] in;
    logic        in_valid;
    logic [31:0] out;
    logic [31:0] out_q;
    logic        out_valid;

    int unsigned total;
    int unsigned bad;

    logic [31:0] m_q;
    logic        m_v;

    ext_16_32_core #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: signed view vs unsigned view of the 16-bit field.
    function automatic logic [31:0] ref_ext(input logic s, input logic [15:0] v);
        int signed sv;
        int unsigned uv;
        sv = int'($signed(v));
        uv = 32'(v);
        return s ? 32'(sv) : uv;
    endfunction

    // Drive one cycle between edges, check both paths.
    task automatic step(input string tag, input logic s, input logic [15:0] v, input logic vld);
        @(negedge clk);
        sel = s;
        in = v;
        in_valid = vld;
        #1;
        chk({tag, "_comb"}, out, ref_ext(s, v));
        @(posedge clk);
        if (vld) m_q = ref_ext(s, v);
        m_v = vld;
        #1;
        chk({tag, "_q"}, out_q, m_q);
        chk({tag, "_v"}, 32'(out_valid), 32'(m_v));
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        sel = 1'b0;
        in = 16'd0;
        in_valid = 1'b0;
        m_q = 32'd0;
        m_v = 1'b0;

        #2;
        in = 16'h8001;
        sel = 1'b1;
        #1;
        chk("rst_q", out_q, 32'd0);
        chk("rst_v", 32'(out_valid), 32'd0);
        chk("rst_comb", out, 32'hFFFF8001);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed values from the datasheet examples.
        step("t1", 1'b0, 16'd123, 1'b1);
        chk("t1_lit", out_q, 32'h0000007B);
        step("t2", 1'b1, 16'd123, 1'b1);
        step("t3z", 1'b0, 16'hFF85, 1'b1);
        chk("t3z_lit", out_q, 32'h0000FF85);
        step("t3s", 1'b1, 16'hFF85, 1'b1);
        chk("t3s_lit", out_q, 32'hFFFFFF85);
        step("t4a", 1'b1, 16'h8000, 1'b1);
        chk("t4a_lit", out_q, 32'hFFFF8000);
        step("t4b", 1'b0, 16'h8000, 1'b1);
        chk("t4b_lit", out_q, 32'h00008000);
        step("t4c", 1'b1, 16'h7FFF, 1'b1);
        chk("t4c_lit", out_q, 32'h00007FFF);
        step("t4d", 1'b1, 16'hFFFF, 1'b1);
        chk("t4d_lit", out_q, 32'hFFFFFFFF);

        // Back-to-back alternating, then idle hold.
        for (int i = 0; i < 6; i++) begin
            step("t5", 1'(i % 2), 16'($urandom), 1'b1);
        end
        step("t5_idle", 1'b1, 16'hABCD, 1'b0);
        step("t5_idle2", 1'b0, 16'h1234, 1'b0);

        for (int i = 0; i < 200; i++) begin
            step("rnd", 1'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Mid-cycle async reset discards the captured result.
        step("t6_pre", 1'b1, 16'h9000, 1'b1);
        @(posedge clk);
        m_v = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        m_q = 32'd0;
        m_v = 1'b0;
        chk("t6_q", out_q, 32'd0);
        chk("t6_v", 32'(out_valid), 32'd0);
        in = 16'hC001;
        sel = 1'b1;
        #1;
        chk("t6_comb", out, 32'hFFFFC001);
        @(posedge clk);
        #1;
        chk("t6_hold_q", out_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_post", 1'b0, 16'hC001, 1'b1);
        chk("t6_post_lit", out_q, 32'h0000C001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
